// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one Sysbus request/response
// channel among NUM_PORTS clients, one outstanding transaction at a time.
//
// Ports:
//   clk, reset (async, active low)
//   port_reqcyc/reqwr/req/reqtag -> per-port request (address, then write data)
//   port_reqack                  <- per-port beat accepted
//   port_respcyc/resp/resptag    <- response beat (data/tag broadcast)
//   port_respack                 -> per-port response beat consumed
//   bus_reqcyc/req/reqtag/reqack    Sysbus request channel
//   bus_respcyc/resp/resptag/respack Sysbus response channel
//   owner, busy                  <- debug/perf visibility
//
// Build option: define BUS_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest index wins, so fetch on port 0 always goes first).
module bus_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int RESP_BEATS     = 8,
    parameter int WR_BEATS       = 8,
    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                port_reqcyc,
    input  logic [NUM_PORTS-1:0]                port_reqwr,
    input  logic [NUM_PORTS*BUS_DATA_WIDTH-1:0] port_req,
    input  logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]  port_reqtag,
    output logic [NUM_PORTS-1:0]                port_reqack,
    output logic [NUM_PORTS-1:0]                port_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]           port_resp,
    output logic [BUS_TAG_WIDTH-1:0]            port_resptag,
    input  logic [NUM_PORTS-1:0]                port_respack,
    output logic                                bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]           bus_req,
    output logic [BUS_TAG_WIDTH-1:0]            bus_reqtag,
    input  logic                                bus_reqack,
    input  logic                                bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]           bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]            bus_resptag,
    output logic                                bus_respack,
    output logic [OW-1:0]                       owner,
    output logic                                busy
);

    localparam int MAXB = (RESP_BEATS > WR_BEATS) ? RESP_BEATS : WR_BEATS;
    localparam int CW   = $clog2(MAXB + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RESP,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [OW-1:0]              owner_q, owner_d;
    logic [OW-1:0]              rr_q, rr_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                       wr_q, wr_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic                       gnt_vld;
    logic [OW-1:0]              gnt_idx;

    logic [BUS_DATA_WIDTH-1:0]  own_req;
    logic [BUS_TAG_WIDTH-1:0]   own_tag;
    logic                       own_cyc;
    logic                       own_respack;
    logic                       tag_hit;

    // Owner-selected request/response signals, muxed from the registered owner
    assign own_req     = port_req[int'(owner_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign own_tag     = port_reqtag[int'(owner_q)*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    assign own_cyc     = port_reqcyc[owner_q];
    assign own_respack = port_respack[owner_q];
    assign tag_hit     = bus_respcyc && (bus_resptag == tag_q);

    // Grant selection
`ifdef BUS_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Descending scan so the lowest asserted index is the last writer
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_reqcyc[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = OW'(i);
            end
        end
    end
`else
    always_comb begin
        int k;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        // Scan starting at rr pointer, wrapping past the last port
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = int'(rr_q) + i;
            if (k >= NUM_PORTS) k = k - NUM_PORTS;
            if (!gnt_vld && port_reqcyc[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = OW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        tag_d        = tag_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        bus_respack  = 1'b0;
        port_reqack  = '0;
        port_respcyc = '0;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    tag_d   = port_reqtag[int'(gnt_idx)*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                    wr_d    = port_reqwr[gnt_idx];
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = own_req;
                bus_reqtag = own_tag;
                if (bus_reqack) begin
                    port_reqack[owner_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = wr_q ? S_WDATA : S_RESP;
                end
            end
            S_WDATA: begin
                // Owner may pause the data stream by dropping reqcyc
                bus_reqcyc = own_cyc;
                bus_req    = own_req;
                bus_reqtag = tag_q;
                if (own_cyc && bus_reqack) begin
                    port_reqack[owner_q] = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WR_BEATS - 1)) state_d = S_DONE;
                end
            end
            S_RESP: begin
                // Beats carrying a foreign tag are neither forwarded nor acked
                if (tag_hit) begin
                    port_respcyc[owner_q] = 1'b1;
                    bus_respack = own_respack;
                    if (own_respack) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(RESP_BEATS - 1)) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (int'(owner_q) == NUM_PORTS - 1) rr_d = '0;
                else rr_d = owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            tag_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign port_resp    = bus_resp;
    assign port_resptag = bus_resptag;
    assign owner        = owner_q;
    assign busy         = (state_q == S_REQ) || (state_q == S_WDATA) ||
                          (state_q == S_RESP);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs driven 1 time unit after posedge, outputs checked on negedge.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int TW = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    port_reqcyc;
    logic [N-1:0]    port_reqwr;
    logic [N*DW-1:0] port_req;
    logic [N*TW-1:0] port_reqtag;
    logic [N-1:0]    port_reqack;
    logic [N-1:0]    port_respcyc;
    logic [DW-1:0]   port_resp;
    logic [TW-1:0]   port_resptag;
    logic [N-1:0]    port_respack;
    logic            bus_reqcyc;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack;
    logic            bus_respcyc;
    logic [DW-1:0]   bus_resp;
    logic [TW-1:0]   bus_resptag;
    logic            bus_respack;
    logic [0:0]      owner;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .NUM_PORTS(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW),
        .RESP_BEATS(8), .WR_BEATS(8)
    ) dut (
        .clk(clk), .reset(reset),
        .port_reqcyc(port_reqcyc), .port_reqwr(port_reqwr),
        .port_req(port_req), .port_reqtag(port_reqtag),
        .port_reqack(port_reqack), .port_respcyc(port_respcyc),
        .port_resp(port_resp), .port_resptag(port_resptag),
        .port_respack(port_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, busy, bus_respack} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl: reqcyc/busy/respack=%b exp 000",
                     {bus_reqcyc, busy, bus_respack});
        end
        checks++;
        if ({port_reqack, port_respcyc, owner} !== 5'b0) begin
            failures++;
            $display("FAIL reset_port: reqack=%b respcyc=%b owner=%0d exp 0",
                     port_reqack, port_respcyc, owner);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: reqcyc/busy=%b exp 00", {bus_reqcyc, busy});
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        logic [N-1:0] exp_ack;
        port_reqcyc = 2'b01;
        port_reqwr  = 2'b00;
        port_req[DW-1:0]    = 64'h1000;
        port_reqtag[TW-1:0] = 13'h005;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            bus_reqack = (c == 2);
            exp_ack = (c == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++;
            if ({bus_reqcyc, busy, owner} !== 3'b110 || bus_req !== 64'h1000 ||
                bus_reqtag !== 13'h005) begin
                failures++;
                $display("FAIL rd_req c%0d: cyc=%b busy=%b own=%0d req=%h tag=%h exp 1 1 0 1000 005",
                         c, bus_reqcyc, busy, owner, bus_req, bus_reqtag);
            end
            checks++;
            if (port_reqack !== exp_ack) begin
                failures++;
                $display("FAIL rd_reqack c%0d: got %b exp %b", c, port_reqack, exp_ack);
            end
            next_cycle();
        end
        port_reqcyc = 2'b00;
        bus_reqack  = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus_respcyc  = 1'b1;
            bus_resp     = 64'hA0 + 64'(b);
            bus_resptag  = 13'h005;
            port_respack = 2'b01;
            @(negedge clk);
            checks++;
            if (port_respcyc !== 2'b01 || bus_respack !== 1'b1 ||
                port_resp !== 64'hA0 + 64'(b) || bus_reqcyc !== 1'b0) begin
                failures++;
                $display("FAIL rd_beat%0d: respcyc=%b respack=%b data=%h reqcyc=%b exp 01 1 %h 0",
                         b, port_respcyc, bus_respack, port_resp, bus_reqcyc, 64'hA0 + 64'(b));
            end
            next_cycle();
        end
        bus_respcyc  = 1'b0;
        port_respack = 2'b00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || port_respcyc !== 2'b00) begin
            failures++;
            $display("FAIL rd_done: busy=%b respcyc=%b exp 0 00", busy, port_respcyc);
        end
        next_cycle();
    endtask

    task automatic test_write();
        int beat = 0;
        int pulses = 0;
        int stall = 0;
        logic ack_t = 1'b0;
        logic got;
        logic [DW-1:0] exp_req;
        port_reqcyc = 2'b10;
        port_reqwr  = 2'b10;
        port_req[2*DW-1:DW]    = 64'h2000;
        port_reqtag[2*TW-1:TW] = 13'h0AA;
        next_cycle();
        for (int cyc = 0; cyc < 40 && pulses < 9; cyc++) begin
            bus_reqack = ack_t;
            ack_t = ~ack_t;
            if (beat == 4 && stall < 2) begin
                port_reqcyc[1] = 1'b0;
                stall++;
            end else begin
                port_reqcyc[1] = 1'b1;
            end
            exp_req = (beat == 0) ? 64'h2000 : 64'h10 + 64'(beat - 1);
            @(negedge clk);
            got = port_reqack[1];
            checks++;
            if (bus_reqcyc !== port_reqcyc[1] ||
                (port_reqcyc[1] && bus_req !== exp_req)) begin
                failures++;
                $display("FAIL wr_req beat%0d: cyc=%b req=%h exp %b %h",
                         beat, bus_reqcyc, bus_req, port_reqcyc[1], exp_req);
            end
            checks++;
            if (port_reqack !== {bus_reqack & port_reqcyc[1], 1'b0} ||
                bus_respack !== 1'b0) begin
                failures++;
                $display("FAIL wr_ack beat%0d: reqack=%b respack=%b exp %b 0",
                         beat, port_reqack, bus_respack,
                         {bus_reqack & port_reqcyc[1], 1'b0});
            end
            next_cycle();
            if (got) begin
                pulses++;
                beat++;
                port_req[2*DW-1:DW] = 64'h10 + 64'(beat - 1);
                if (beat == 9) port_reqcyc = 2'b00;
            end
        end
        checks++;
        if (pulses != 9) begin
            failures++;
            $display("FAIL wr_pulses: got %0d exp 9", pulses);
        end
        port_reqcyc = 2'b00;
        port_reqwr  = 2'b00;
        bus_reqack  = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, busy, port_reqack} !== 4'b0) begin
            failures++;
            $display("FAIL wr_done: cyc=%b busy=%b reqack=%b exp 0 0 00",
                     bus_reqcyc, busy, port_reqack);
        end
        next_cycle();
        bus_reqack = 1'b0;
    endtask

    task automatic test_contention();
        int exp;
        logic [N-1:0] exp_oh;
        logic [TW-1:0] tg;
        port_reqcyc = 2'b11;
        port_reqwr  = 2'b00;
        port_req    = {64'h4000, 64'h3000};
        port_reqtag = {13'h022, 13'h011};
        next_cycle();
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = k % 2;
`endif
            exp_oh = 2'b01 << exp;
            tg = (exp == 1) ? 13'h022 : 13'h011;
            bus_reqack = 1'b1;
            @(negedge clk);
            checks++;
            if (bus_reqcyc !== 1'b1 || int'(owner) != exp ||
                port_reqack !== exp_oh || bus_reqtag !== tg) begin
                failures++;
                $display("FAIL cont_grant%0d: cyc=%b owner=%0d reqack=%b tag=%h exp 1 %0d %b %h",
                         k, bus_reqcyc, owner, port_reqack, bus_reqtag, exp, exp_oh, tg);
            end
            next_cycle();
            bus_reqack = 1'b0;
            for (int b = 0; b < 8; b++) begin
                bus_respcyc  = 1'b1;
                bus_resptag  = tg;
                bus_resp     = 64'(k * 16 + b);
                port_respack = 2'b11;
                @(negedge clk);
                checks++;
                if (port_respcyc !== exp_oh || port_reqack !== 2'b00) begin
                    failures++;
                    $display("FAIL cont_beat%0d_%0d: respcyc=%b reqack=%b exp %b 00",
                             k, b, port_respcyc, port_reqack, exp_oh);
                end
                next_cycle();
            end
            bus_respcyc  = 1'b0;
            port_respack = 2'b00;
            if (k == 3) port_reqcyc = 2'b00;
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                checks++;
                if ({bus_reqcyc, busy} !== 2'b00) begin
                    failures++;
                    $display("FAIL cont_gap%0d_%0d: cyc/busy=%b exp 00",
                             k, g, {bus_reqcyc, busy});
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_tag_filter();
        int idx = 0;
        port_reqcyc = 2'b01;
        port_req[DW-1:0]    = 64'h5000;
        port_reqtag[TW-1:0] = 13'h005;
        next_cycle();
        bus_reqack = 1'b1;
        @(negedge clk);
        checks++;
        if (port_reqack !== 2'b01) begin
            failures++;
            $display("FAIL tag_reqack: got %b exp 01", port_reqack);
        end
        next_cycle();
        bus_reqack  = 1'b0;
        port_reqcyc = 2'b00;
        for (int b = 0; b < 9; b++) begin
            bus_respcyc  = 1'b1;
            port_respack = 2'b01;
            if (b == 2) begin
                bus_resptag = 13'h006;
                bus_resp    = 64'hEE;
                @(negedge clk);
                checks++;
                if (port_respcyc !== 2'b00 || bus_respack !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL tag_foreign: respcyc=%b respack=%b busy=%b exp 00 0 1",
                             port_respcyc, bus_respack, busy);
                end
            end else begin
                bus_resptag = 13'h005;
                bus_resp    = 64'hB0 + 64'(idx);
                @(negedge clk);
                checks++;
                if (port_respcyc !== 2'b01 || bus_respack !== 1'b1 ||
                    port_resp !== 64'hB0 + 64'(idx) || port_resptag !== 13'h005) begin
                    failures++;
                    $display("FAIL tag_beat%0d: respcyc=%b respack=%b data=%h tag=%h exp 01 1 %h 005",
                             idx, port_respcyc, bus_respack, port_resp, port_resptag,
                             64'hB0 + 64'(idx));
                end
                idx++;
            end
            next_cycle();
        end
        bus_respcyc  = 1'b0;
        port_respack = 2'b00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tag_done: busy=%b exp 0", busy);
        end
        next_cycle();
    endtask

    task automatic test_backpressure_reset();
        port_reqcyc = 2'b01;
        port_req[DW-1:0]    = 64'h7000;
        port_reqtag[TW-1:0] = 13'h005;
        next_cycle();
        bus_reqack = 1'b1;
        next_cycle();
        bus_reqack  = 1'b0;
        port_reqcyc = 2'b00;
        bus_resptag = 13'h005;
        bus_respcyc = 1'b1;
        for (int c = 0; c < 9; c++) begin
            // beats 0-2 accepted, 4 stalled cycles, then 2 more beats
            port_respack = (c >= 3 && c < 7) ? 2'b00 : 2'b01;
            bus_resp = 64'hC0 + 64'(c);
            @(negedge clk);
            checks++;
            if (port_respcyc !== 2'b01 || bus_respack !== port_respack[0] ||
                busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_cycle%0d: respcyc=%b respack=%b busy=%b exp 01 %b 1",
                         c, port_respcyc, bus_respack, busy, port_respack[0]);
            end
            next_cycle();
        end
        port_respack = 2'b01;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_reqcyc, bus_respack, busy, owner} !== 4'b0 ||
            port_respcyc !== 2'b00 || port_reqack !== 2'b00) begin
            failures++;
            $display("FAIL async_reset: cyc=%b respack=%b busy=%b own=%0d respcyc=%b reqack=%b exp all 0",
                     bus_reqcyc, bus_respack, busy, owner, port_respcyc, port_reqack);
        end
        next_cycle();
        reset        = 1'b1;
        bus_respcyc  = 1'b0;
        port_respack = 2'b00;
        @(negedge clk);
        checks++;
        if ({bus_reqcyc, busy} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset: cyc/busy=%b exp 00", {bus_reqcyc, busy});
        end
        next_cycle();
        port_reqcyc = 2'b10;
        port_req[2*DW-1:DW] = 64'h6000;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus_reqcyc !== 1'b1 || owner !== 1'b1 || bus_req !== 64'h6000) begin
            failures++;
            $display("FAIL post_reset_grant: cyc=%b owner=%0d req=%h exp 1 1 6000",
                     bus_reqcyc, owner, bus_req);
        end
        next_cycle();
    endtask

    initial begin
        reset        = 1'b0;
        port_reqcyc  = '0;
        port_reqwr   = '0;
        port_req     = '0;
        port_reqtag  = '0;
        port_respack = '0;
        bus_reqack   = 1'b0;
        bus_respcyc  = 1'b0;
        bus_resp     = '0;
        bus_resptag  = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_tag_filter();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
